lcd_px_stage: RTL and testbench



---
 rtl/lcd_px_stage_pkg.sv | 8 +
 rtl/lcd_px_stage_fifo.sv | 44 ++++
 rtl/lcd_px_stage.sv | 128 ++++++++++++
 tb/tb_lcd_px_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_px_stage_pkg.sv
// lcd_pkg: shared state encoding, pixel type and default geometry for the LCD pixel stage
package lcd_pkg;
  typedef enum logic [2:0] {OFF, WAIT_FRAME, HSYNC, ACTIVE, DONE} state_t;
  typedef logic [1:0] px_t;
  localparam int PX_PER_LINE_D = 160;
  localparam int LINES_D = 154;
  localparam int VISIBLE_LINES_D = 144;
endpackage

// File: rtl/lcd_px_stage_fifo.sv
// lcd_px_fifo: small pixel FIFO with flush; a push in a flush cycle lands as the sole entry
module lcd_px_fifo import lcd_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  px_t                      din,
  output px_t                      dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  px_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic wr_en, rd_en;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr_en = push & (!full | flush);
  assign rd_en = pop & !empty & !flush;
  assign dout = mem[rd];
  // pointer and occupancy tracking; flush empties the queue before any same-cycle push
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= AW'(wr_en);
      count <= CW'(wr_en);
    end else begin
      rd <= rd + AW'(rd_en);
      wr <= wr + AW'(wr_en);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  // storage array, written at slot 0 when the push rides along with a flush
  always_ff @(posedge clk)
    if (wr_en) mem[flush ? '0 : wr] <= din;
endmodule

// File: rtl/lcd_px_stage.sv
// lcd_px_stage: PPU-to-LCD pixel output stage; define LCD_PX_STATS_EN for drop/short-line counters
module lcd_px_stage import lcd_pkg::*; #(
  parameter int FIFO_DEPTH    = 8,
  parameter int PX_PER_LINE   = PX_PER_LINE_D,
  parameter int LINES         = LINES_D,
  parameter int VISIBLE_LINES = VISIBLE_LINES_D,
  parameter int HSYNC_LEN     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcdc_on,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic       in_push,
  input  px_t        in_px,
  output logic       in_full,
  output logic       disp_on,
  output logic       hsync,
  output logic       vsync,
  output logic       px_out,
  output px_t        px,
  output logic       err_ovf,
`ifdef LCD_PX_STATS_EN
  output logic [7:0] stat_drop,
  output logic [7:0] stat_short,
`endif
  output logic       err_short
);
  localparam int LW = $clog2(LINES);
  localparam int PW = $clog2(PX_PER_LINE + 1);
  localparam int HW = $clog2(HSYNC_LEN) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  logic [LW-1:0] line_cnt, line_n, line_nx;
  logic [PW-1:0] px_cnt, px_n;
  logic [HW-1:0] hs_cnt, hs_n;
  logic [CW-1:0] fifo_count;
  logic fifo_empty, vs_n, busy, restart, vis, elig, push_ok, pop, flush, ovf_ev, short_ev;
  px_t fifo_dout;
  assign busy = state inside {HSYNC, ACTIVE, DONE};
  assign restart = lcdc_on & busy & line_start;
  assign line_nx = (frame_start || line_cnt == LW'(LINES - 1)) ? '0 : line_cnt + 1'b1;
  assign vis = (restart ? line_nx : line_cnt) < LW'(VISIBLE_LINES);
  assign elig = lcdc_on & busy & in_push & vis;
  assign push_ok = elig & (!in_full | restart);
  assign ovf_ev = elig & in_full & !restart;
  assign short_ev = restart & state == ACTIVE & px_cnt < PW'(PX_PER_LINE);
  assign pop = lcdc_on & !line_start & state == ACTIVE & fifo_count != '0;
  assign flush = !lcdc_on | restart;
  lcd_px_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push_ok), .pop(pop), .flush(flush), .din(in_px),
    .dout(fifo_dout), .count(fifo_count), .full(in_full), .empty(fifo_empty)
  );
  // line/frame sequencing: line_start always wins over the per-state progression
  always_comb begin
    state_n = state;
    line_n = line_cnt;
    px_n = px_cnt;
    hs_n = hs_cnt;
    vs_n = vsync;
    if (!lcdc_on) begin
      state_n = OFF;
      vs_n = 1'b0;
    end else if (restart) begin
      state_n = HSYNC;
      line_n = line_nx;
      px_n = '0;
      hs_n = '0;
      vs_n = line_nx == '0;
    end else case (state)
      OFF: state_n = WAIT_FRAME;
      WAIT_FRAME: if (frame_start) begin
        state_n = HSYNC;
        line_n = '0;
        px_n = '0;
        hs_n = '0;
        vs_n = 1'b1;
      end
      HSYNC: begin
        hs_n = hs_cnt + 1'b1;
        if (hs_cnt == HW'(HSYNC_LEN - 1)) state_n = line_cnt < LW'(VISIBLE_LINES) ? ACTIVE : DONE;
      end
      ACTIVE: if (pop && !fifo_empty) begin
        px_n = px_cnt + 1'b1;
        if (px_cnt == PW'(PX_PER_LINE - 1)) state_n = DONE;
      end
      default: ;
    endcase
  end
  // state and registered driver-side outputs; error flags hold until the LCD is disabled
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= OFF;
      line_cnt <= '0;
      px_cnt <= '0;
      hs_cnt <= '0;
      disp_on <= 1'b0;
      hsync <= 1'b0;
      vsync <= 1'b0;
      px_out <= 1'b0;
      px <= '0;
      err_ovf <= 1'b0;
      err_short <= 1'b0;
    end else begin
      state <= state_n;
      line_cnt <= line_n;
      px_cnt <= px_n;
      hs_cnt <= hs_n;
      disp_on <= state_n != OFF;
      hsync <= state_n == HSYNC;
      vsync <= vs_n;
      px_out <= pop;
      px <= pop ? fifo_dout : '0;
      err_ovf <= lcdc_on & (err_ovf | ovf_ev);
      err_short <= lcdc_on & (err_short | short_ev);
    end
`ifdef LCD_PX_STATS_EN
  // saturating event counters, cleared together with the error flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_drop <= '0;
      stat_short <= '0;
    end else begin
      stat_drop <= lcdc_on ? stat_drop + 8'(ovf_ev & ~&stat_drop) : '0;
      stat_short <= lcdc_on ? stat_short + 8'(short_ev & ~&stat_short) : '0;
    end
`endif
endmodule

// File: tb/tb_lcd_px_stage.sv
// tb_lcd_px_stage: directed plus random stimulus against a queue-based reference model
module tb_lcd_px_stage;
  import lcd_pkg::*;
  localparam int FD = 8, PX = 160, LN = 154, VIS = 144, HL = 2;
  localparam int M_OFF = 0, M_WAIT = 1, M_HS = 2, M_ACT = 3, M_DONE = 4;
  logic clk = 1'b0, reset = 1'b1, lcdc_on = 1'b0, line_start = 1'b0, frame_start = 1'b0, in_push = 1'b0;
  px_t in_px = '0;
  logic in_full, disp_on, hsync, vsync, px_out, err_ovf, err_short;
  px_t px;
`ifdef LCD_PX_STATS_EN
  logic [7:0] stat_drop, stat_short;
`endif
  int checks = 0, errors = 0, npx = 0, base = 0;
  int mst = M_OFF, hleft = 0, line = 0, pxn = 0, ndrop = 0, nshort = 0;
  bit vs = 0, ovf = 0, shrt = 0, e_pxo = 0;
  logic [1:0] e_px = '0;
  logic [1:0] q[$];

  always #5 clk = ~clk;

  lcd_px_stage #(.FIFO_DEPTH(FD), .PX_PER_LINE(PX), .LINES(LN), .VISIBLE_LINES(VIS), .HSYNC_LEN(HL)) dut (
    .clk(clk), .reset(reset), .lcdc_on(lcdc_on), .line_start(line_start), .frame_start(frame_start),
    .in_push(in_push), .in_px(in_px), .in_full(in_full), .disp_on(disp_on), .hsync(hsync),
    .vsync(vsync), .px_out(px_out), .px(px), .err_ovf(err_ovf),
`ifdef LCD_PX_STATS_EN
    .stat_drop(stat_drop), .stat_short(stat_short),
`endif
    .err_short(err_short)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: one clock of the stage described as queue operations and line bookkeeping
  task automatic model(input bit l, input bit ls, input bit fs, input bit p, input logic [1:0] d);
    bit busy, full;
    e_pxo = 0;
    e_px = '0;
    if (!l) begin
      mst = M_OFF; q.delete(); ovf = 0; shrt = 0; vs = 0; ndrop = 0; nshort = 0;
      return;
    end
    busy = mst >= M_HS;
    full = q.size() == FD;
    if (busy && ls) begin
      if (mst == M_ACT && pxn < PX) begin
        shrt = 1;
        nshort = nshort < 255 ? nshort + 1 : 255;
      end
      line = fs ? 0 : (line + 1) % LN;
      q.delete(); pxn = 0; mst = M_HS; hleft = HL; vs = line == 0;
    end else if (mst == M_OFF) mst = M_WAIT;
    else if (mst == M_WAIT) begin
      if (fs) begin mst = M_HS; hleft = HL; line = 0; pxn = 0; vs = 1; end
    end else if (mst == M_HS) begin
      hleft--;
      if (hleft == 0) mst = line < VIS ? M_ACT : M_DONE;
    end else if (mst == M_ACT && q.size() > 0) begin
      e_px = q.pop_front(); e_pxo = 1; pxn++;
      if (pxn == PX) mst = M_DONE;
    end
    if (p && busy && line < VIS) begin
      if (full && !ls) begin
        ovf = 1;
        ndrop = ndrop < 255 ? ndrop + 1 : 255;
      end else q.push_back(d);
    end
  endtask

  task automatic step(input bit l, input bit ls, input bit fs, input bit p, input logic [1:0] d);
    lcdc_on = l; line_start = ls; frame_start = fs; in_push = p; in_px = d;
    @(posedge clk);
    model(l, ls, fs, p, d);
    #1;
    if (px_out === 1'b1) npx++;
    chk("disp_on", disp_on, mst != M_OFF);
    chk("hsync", hsync, mst == M_HS);
    chk("vsync", vsync, vs);
    chk("px_out", px_out, e_pxo);
    chk("px", px, e_px);
    chk("in_full", in_full, q.size() == FD);
    chk("err_ovf", err_ovf, ovf);
    chk("err_short", err_short, shrt);
`ifdef LCD_PX_STATS_EN
    chk("stat_drop", stat_drop, ndrop[7:0]);
    chk("stat_short", stat_short, nshort[7:0]);
`endif
  endtask

  task automatic full_line();
    for (int i = 0; i < PX; i++) step(1, 0, 0, 1, 2'(i % 4));
    repeat (10) step(1, 0, 0, 0, 2'b00);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp_on", disp_on, 0);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_px_out", px_out, 0);
    chk("rst_in_full", in_full, 0);
    chk("rst_err_ovf", err_ovf, 0);
    @(negedge clk);
    reset = 1'b0;
    // enable, start a frame, stream a complete line
    repeat (2) step(1, 0, 0, 0, 2'b00);
    step(1, 1, 1, 0, 2'b00);
    chk("fs_hsync", hsync, 1);
    chk("fs_vsync", vsync, 1);
    base = npx;
    full_line();
    chk("line0_px_count", 8'(npx - base), 8'(PX));
    chk("line0_err_short", err_short, 0);
    // line 0 is DONE: nothing drains, so the ninth push overflows
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 1, 2'($urandom));
      if (i == 7) chk("ovf_full_after8", in_full, 1);
    end
    chk("ovf_flag", err_ovf, 1);
    // short line: 100 pixels then a new line_start
    step(1, 1, 0, 0, 2'b00);
    base = npx;
    for (int i = 0; i < 100; i++) step(1, 0, 0, 1, 2'($urandom));
    repeat (10) step(1, 0, 0, 0, 2'b00);
    chk("short_px_count", 8'(npx - base), 8'd100);
    step(1, 1, 0, 0, 2'b00);
    chk("short_flag", err_short, 1);
    chk("short_hsync", hsync, 1);
    step(1, 0, 0, 1, 2'b11);
    chk("short_flushed", in_full, 0);
    // whole frame of short lines, including the vblank region
    step(0, 0, 0, 0, 2'b00);
    repeat (2) step(1, 0, 0, 0, 2'b00);
    step(1, 1, 1, 0, 2'b00);
    for (int ln = 1; ln < LN; ln++) begin
      if (ln == VIS) base = npx;
      step(1, 1, 0, 0, 2'b00);
      repeat ($urandom_range(3, 6)) step(1, 0, 0, 1'($urandom), 2'($urandom));
    end
    chk("vblank_px_count", 8'(npx - base), 0);
    chk("vblank_ovf", err_ovf, 0);
    chk("vblank_vsync", vsync, 0);
    step(1, 1, 1, 0, 2'b00);
    chk("wrap_vsync", vsync, 1);
    // fill line 0, buffer five more in DONE, then disable
    full_line();
    repeat (5) step(1, 0, 0, 1, 2'($urandom));
    step(0, 0, 0, 1, 2'b10);
    chk("off_disp_on", disp_on, 0);
    chk("off_err_short", err_short, 0);
    chk("off_in_full", in_full, 0);
    base = npx;
    repeat (30) step(1, $urandom_range(0, 5) == 0, 0, 1, 2'($urandom));
    chk("reenable_no_px", 8'(npx - base), 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit fs;
      fs = $urandom_range(0, 599) == 0;
      step($urandom_range(0, 499) != 0, fs | ($urandom_range(0, 249) == 0), fs,
           $urandom_range(0, 9) < 7, 2'($urandom));
    end
    // many overflow drops in a DONE line
    step(0, 0, 0, 0, 2'b00);
    repeat (2) step(1, 0, 0, 0, 2'b00);
    step(1, 1, 1, 0, 2'b00);
    full_line();
    repeat (300) step(1, 0, 0, 1, 2'($urandom));
    chk("drops_ovf", err_ovf, 1);
`ifdef LCD_PX_STATS_EN
    chk("stat_drop_sat", stat_drop, 8'd255);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
